// File: rtl/signature_checker_if.sv
// Bit-stream and status bundle for signature_checker. ERR_W must match the checker's ERR_W.
interface signature_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             ld;
  logic             en;
  logic             d;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [15:0]      bit_count;
  logic [15:0]      first_err_idx;

  modport master (
    output ld, en, d,
    input  busy, done, pass, err_count, bit_count, first_err_idx
  );

  modport slave (
    input  ld, en, d,
    output busy, done, pass, err_count, bit_count, first_err_idx
  );
endinterface

// File: rtl/signature_checker.sv
// Receive-side signature checker: compares d against the parity of an 8-bit up-counter.
// Optional SIG_CHK_FIRST_ERR_EN records the 0-based index of the window's first mismatch.
module signature_checker #(
  parameter logic [7:0]  SEED   = 8'h55,
  parameter int unsigned LENGTH = 16,
  parameter int unsigned ERR_W  = 8
) (
  input logic                clk,
  input logic                reset,
  signature_checker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

  state_e           state_q;
  logic [7:0]       exp_cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [15:0]      bit_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;
  logic [15:0]      bit_nxt;
  logic             last_bit;

  always_comb begin
    mismatch = bus.d != ^exp_cnt_q;
    err_nxt  = err_q;
    if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_nxt = err_q + ERR_W'(1);
    end
    bit_nxt  = bit_q + 16'd1;
    last_bit = bit_nxt == 16'(LENGTH);
  end

`ifdef SIG_CHK_FIRST_ERR_EN
  // 16'hFFFF doubles as "no mismatch yet"; bit indices never reach it.
  logic [15:0] first_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      exp_cnt_q <= SEED;
      err_q     <= '0;
      bit_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef SIG_CHK_FIRST_ERR_EN
      first_q   <= 16'hFFFF;
`endif
    end else if (bus.ld) begin
      // Restart wins over a same-cycle en; that bit is dropped.
      state_q   <= StCheck;
      exp_cnt_q <= SEED;
      err_q     <= '0;
      bit_q     <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef SIG_CHK_FIRST_ERR_EN
      first_q   <= 16'hFFFF;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
        end
        StCheck: begin
          done_q <= 1'b0;
          if (bus.en) begin
            exp_cnt_q <= exp_cnt_q + 8'd1;
            bit_q     <= bit_nxt;
            err_q     <= err_nxt;
`ifdef SIG_CHK_FIRST_ERR_EN
            if (mismatch && (first_q == 16'hFFFF)) begin
              first_q <= bit_q;
            end
`endif
            if (last_bit) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= err_nxt == '0;
            end
          end
        end
        StDone: begin
          done_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.bit_count = bit_q;
`ifdef SIG_CHK_FIRST_ERR_EN
  assign bus.first_err_idx = first_q;
`else
  assign bus.first_err_idx = 16'hFFFF;
`endif

endmodule

// File: tb/tb_signature_checker.sv
// Randomized + directed bench for signature_checker; three instances share one input stream
// and are checked every cycle against a window-level reference model.
module tb_signature_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  signature_checker_if #(.ERR_W(8)) bus0 ();
  signature_checker_if #(.ERR_W(2)) bus1 ();
  signature_checker_if #(.ERR_W(8)) bus2 ();

  signature_checker #(.SEED(8'h55), .LENGTH(16), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  signature_checker #(.SEED(8'h55), .LENGTH(16), .ERR_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  signature_checker #(.SEED(8'hFE), .LENGTH(4), .ERR_W(8)) u_dut_wrap (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: per instance, a window is "armed" (0 idle, 1 check, 2 done) with n bits taken.
  int m_seed [3] = '{85, 85, 254};
  int m_len  [3] = '{16, 16, 4};
  int m_max  [3] = '{255, 3, 255};
  int m_st   [3];
  int m_n    [3];
  int m_err  [3];
  int m_first[3];
  bit m_done [3];

  function automatic bit par(input int v);
    logic [7:0] b;
    b = 8'(v);
    return ^b;
  endfunction

  task automatic model_step(input bit r, input bit l, input bit e, input bit dd);
    for (int k = 0; k < 3; k++) begin
      m_done[k] = 1'b0;
      if (r || l) begin
        m_st[k]    = r ? 0 : 1;
        m_n[k]     = 0;
        m_err[k]   = 0;
        m_first[k] = 'hFFFF;
      end else if (m_st[k] == 1 && e) begin
        if (dd != par(m_seed[k] + m_n[k])) begin
          if (m_first[k] == 'hFFFF) m_first[k] = m_n[k];
          if (m_err[k] < m_max[k]) m_err[k]++;
        end
        m_n[k]++;
        if (m_n[k] == m_len[k]) begin
          m_st[k]   = 2;
          m_done[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp_inst(input int k, input logic busy, input logic done, input logic pass,
                          input logic [7:0] err, input logic [15:0] bc, input logic [15:0] fe);
    logic [15:0] fe_exp;
`ifdef SIG_CHK_FIRST_ERR_EN
    fe_exp = 16'(m_first[k]);
`else
    fe_exp = 16'hFFFF;
`endif
    check($sformatf("i%0d busy", k), 32'(busy), 32'(m_st[k] == 1));
    check($sformatf("i%0d done", k), 32'(done), 32'(m_done[k]));
    check($sformatf("i%0d pass", k), 32'(pass), 32'(m_st[k] == 2 && m_err[k] == 0));
    check($sformatf("i%0d err_count", k), 32'(err), 32'(m_err[k]));
    check($sformatf("i%0d bit_count", k), 32'(bc), 32'(m_n[k]));
    check($sformatf("i%0d first_err_idx", k), 32'(fe), 32'(fe_exp));
  endtask

  task automatic cyc(input bit r, input bit l, input bit e, input bit dd);
    @(negedge clk);
    reset = r;
    bus0.ld = l; bus0.en = e; bus0.d = dd;
    bus1.ld = l; bus1.en = e; bus1.d = dd;
    bus2.ld = l; bus2.en = e; bus2.d = dd;
    @(posedge clk);
    model_step(r, l, e, dd);
    #1;
    cmp_inst(0, bus0.busy, bus0.done, bus0.pass, bus0.err_count, bus0.bit_count,
             bus0.first_err_idx);
    cmp_inst(1, bus1.busy, bus1.done, bus1.pass, {6'b0, bus1.err_count}, bus1.bit_count,
             bus1.first_err_idx);
    cmp_inst(2, bus2.busy, bus2.done, bus2.pass, bus2.err_count, bus2.bit_count,
             bus2.first_err_idx);
  endtask

  // Full 16-bit generator stream for SEED 55; inv_mask flips chosen bits.
  task automatic send_stream(input logic [15:0] inv_mask);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, $urandom_range(0, 1) == 1);
      cyc(0, 0, 1, par(85 + i) ^ inv_mask[i]);
    end
  endtask

  initial begin
    bus0.ld = 0; bus0.en = 0; bus0.d = 0;
    bus1.ld = 0; bus1.en = 0; bus1.d = 0;
    bus2.ld = 0; bus2.en = 0; bus2.d = 0;
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_n[k] = 0; m_err[k] = 0; m_first[k] = 'hFFFF; m_done[k] = 0;
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);  // en in IDLE is ignored

    // Clean window; last cyc leaves done/pass visible.
    send_stream(16'h0000);
    check("t1 done", 32'(bus0.done), 32'd1);
    check("t1 pass", 32'(bus0.pass), 32'd1);
    cyc(0, 0, 1, 0);
    check("t1 done pulse width", 32'(bus0.done), 32'd0);

    send_stream(16'h0004);
    check("t2 err_count", 32'(bus0.err_count), 32'd1);
    check("t2 pass", 32'(bus0.pass), 32'd0);

    send_stream(16'hFFFF);
    check("t3 sat err_count", 32'(bus1.err_count), 32'd3);
    check("t3 full err_count", 32'(bus0.err_count), 32'd16);

    // ld and en together: the d=1 bit is dropped.
    cyc(0, 1, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    check("t4 err_count", 32'(bus0.err_count), 32'd0);
    check("t4 bit_count", 32'(bus0.bit_count), 32'd3);

    send_stream(16'h0000);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, par(85 + i));
    cyc(1, 0, 0, 0);
    check("t5 busy", 32'(bus0.busy), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, $urandom_range(0, 1) == 1);
    check("t5 bit_count", 32'(bus0.bit_count), 32'd0);

    // Wrap instance: expected 1,0,0,1 across FE..01.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    check("t6 err_count", 32'(bus2.err_count), 32'd2);
    check("t6 done", 32'(bus2.done), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      bit r, l, e, flip;
      r    = $urandom_range(0, 299) == 0;
      l    = $urandom_range(0, 29) == 0;
      e    = $urandom_range(0, 2) != 0;
      flip = $urandom_range(0, 11) == 0;
      cyc(r, l, e, par(85 + m_n[0]) ^ flip);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
